// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier. One partial-product step per cycle,
// with signed operands handled as magnitudes plus a sign fix-up at the end.
module shift_add_mult #(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2*WIDTH-1:0]  mcand_q;
  logic [2*WIDTH-1:0]  acc_q;
  logic [2*WIDTH-1:0]  acc_sum;
  logic [WIDTH-1:0]    mplier_q;
  logic [WIDTH-1:0]    a_mag;
  logic [WIDTH-1:0]    b_mag;
  logic [CW-1:0]       cnt_q;
  logic                neg_q;
  logic                accept;
  logic                last;

  // Handshake: load is sampled only in IDLE or DONE (busy=0); while busy=1 it
  // is ignored. done is a single-cycle pulse with product valid alongside it.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
          last    = 1'b1;
        end
      end
      DONE: begin
        if (load) begin
          state_d = RUN;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The most negative operand's magnitude still fits as a WIDTH-bit unsigned.
  assign a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

  assign acc_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      product  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mcand_q  <= {{WIDTH{1'b0}}, a_mag};
        mplier_q <= b_mag;
        acc_q    <= '0;
        cnt_q    <= '0;
        neg_q    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (state_q == RUN) begin
        acc_q    <= acc_sum;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CW'(1);
        // Negating a zero magnitude yields zero, so no sign artefact appears.
        if (last) begin
          product <= neg_q ? -acc_sum : acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and randomized bench for shift_add_mult at WIDTH=6 and WIDTH=16,
// compared against a plain integer multiply model.
module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        reset;
  logic        load6, s6, load16, s16;
  logic [5:0]  a6, b6;
  logic [15:0] a16, b16;
  logic [11:0] product6;
  logic [31:0] product16;
  logic        busy6, done6, busy16, done16;
  logic [1:0]  dbg6, dbg16;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_add_mult #(.WIDTH(6)) dut6 (
    .clk(clk), .reset(reset), .load(load6), .signed_mode(s6),
    .a(a6), .b(b6), .product(product6), .busy(busy6), .done(done6),
    .dbg_state(dbg6)
  );

  shift_add_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .load(load16), .signed_mode(s16),
    .a(a16), .b(b16), .product(product16), .busy(busy16), .done(done16),
    .dbg_state(dbg16)
  );

  // Reference: interpret operands as integers, multiply, keep 2*w bits.
  function automatic logic [63:0] model(input int w, input logic [31:0] x,
                                        input logic [31:0] y, input bit sgn);
    longint sx, sy, p;
    longint unsigned mask;
    mask = (64'd1 << (2 * w)) - 64'd1;
    sx = longint'(x) & ((64'sd1 <<< w) - 1);
    sy = longint'(y) & ((64'sd1 <<< w) - 1);
    if (sgn) begin
      if (sx >= (64'sd1 <<< (w - 1))) sx = sx - (64'sd1 <<< w);
      if (sy >= (64'sd1 <<< (w - 1))) sy = sy - (64'sd1 <<< w);
    end
    p = sx * sy;
    return 64'(p) & mask;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=6 operation with full cycle-by-cycle checking; operands are
  // scrambled after accept and an optional between-edge reset glitch is applied.
  task automatic op6(input logic [5:0] ta, input logic [5:0] tb, input bit ts,
                     input bit glitch, input string tag);
    logic [11:0] prev, exp;
    prev = product6;
    exp  = 12'(model(6, 32'(ta), 32'(tb), ts));
    a6 = ta; b6 = tb; s6 = ts; load6 = 1'b1;
    tick();
    load6 = 1'b0;
    a6 = 6'($urandom_range(63)); b6 = 6'($urandom_range(63)); s6 = 1'($urandom_range(1));
    for (int i = 0; i < 6; i++) begin
      chk({tag, "_run"}, {50'd0, busy6, done6, product6}, {50'd0, 1'b1, 1'b0, prev});
      if (glitch && i == 2) begin
        #2 reset = 1'b0;
        #3 reset = 1'b1;
      end
      tick();
    end
    chk({tag, "_done"}, {50'd0, busy6, done6, product6}, {50'd0, 1'b0, 1'b1, exp});
    tick();
    chk({tag, "_idle"}, {50'd0, busy6, done6, product6}, {50'd0, 1'b0, 1'b0, exp});
  endtask

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input bit ts,
                      input string tag);
    logic [31:0] prev, exp;
    prev = product16;
    exp  = 32'(model(16, 32'(ta), 32'(tb), ts));
    a16 = ta; b16 = tb; s16 = ts; load16 = 1'b1;
    tick();
    load16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_run"}, {30'd0, busy16, done16, product16}, {30'd0, 1'b1, 1'b0, prev});
      tick();
    end
    chk({tag, "_done"}, {30'd0, busy16, done16, product16}, {30'd0, 1'b0, 1'b1, exp});
    tick();
    chk({tag, "_idle"}, {30'd0, busy16, done16}, {30'd0, 1'b0, 1'b0});
  endtask

  initial begin
    reset = 1'b0; load6 = 1'b0; s6 = 1'b0; a6 = '0; b6 = '0;
    load16 = 1'b0; s16 = 1'b0; a16 = '0; b16 = '0;
    tick(); tick();
    chk("reset6", {48'd0, busy6, done6, dbg6, product6}, 64'd0);
    chk("reset16", {28'd0, busy16, done16, dbg16, product16}, 64'd0);
    reset = 1'b1;
    tick();

    // Directed products
    op6(6'd5, 6'd6, 1'b0, 1'b0, "u5x6");
    chk("u5x6_val", 64'(product6), 64'd30);
    op6(6'b111011, 6'd6, 1'b1, 1'b0, "s_m5x6");
    chk("s_m5x6_val", 64'(product6), 64'hFE2);
    op6(6'h20, 6'h20, 1'b1, 1'b0, "s_min_sq");
    chk("s_min_sq_val", 64'(product6), 64'h400);
    op6(6'h20, 6'h20, 1'b0, 1'b0, "u_20_sq");
    chk("u_20_sq_val", 64'(product6), 64'h400);
    op6(6'h3F, 6'h3F, 1'b0, 1'b0, "u_max_sq");
    chk("u_max_sq_val", 64'(product6), 64'hF81);
    op6(6'h3F, 6'h3F, 1'b1, 1'b0, "s_m1_sq");
    chk("s_m1_sq_val", 64'(product6), 64'h001);
    op6(6'd0, 6'h25, 1'b1, 1'b0, "s_zero");
    chk("s_zero_val", 64'(product6), 64'd0);
    op6(6'd7, 6'd9, 1'b0, 1'b1, "glitch");

    // Load while busy is ignored
    a6 = 6'd5; b6 = 6'd6; s6 = 1'b0; load6 = 1'b1;
    tick();
    load6 = 1'b0;
    tick();
    a6 = 6'd1; b6 = 6'd1; load6 = 1'b1;
    tick();
    load6 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ign_run", {62'd0, busy6, done6}, {62'd0, 1'b1, 1'b0});
      tick();
    end
    chk("ign_done", {50'd0, busy6, done6, product6}, {50'd0, 1'b0, 1'b1, 12'd30});
    tick();
    chk("ign_idle", {62'd0, busy6, done6}, 64'd0);

    // Back-to-back with load held high
    a6 = 6'd3; b6 = 6'd7; s6 = 1'b0; load6 = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) begin
        chk("b2b_run", {62'd0, busy6, done6}, {62'd0, 1'b1, 1'b0});
        tick();
      end
      chk("b2b_done", {50'd0, busy6, done6, product6}, {50'd0, 1'b0, 1'b1, 12'd21});
      if (r == 2) load6 = 1'b0;
      tick();
    end
    chk("b2b_end", {62'd0, busy6, done6}, 64'd0);

    // Reset on the third RUN cycle aborts the operation
    a6 = 6'd9; b6 = 6'd9; load6 = 1'b1;
    tick();
    load6 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort", {48'd0, busy6, done6, dbg6, product6}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk("abort_nodone", {62'd0, busy6, done6}, 64'd0);
      tick();
    end
    op6(6'd5, 6'd6, 1'b0, 1'b0, "after_abort");
    chk("after_abort_val", 64'(product6), 64'd30);

    // Randomised sweeps at both widths
    for (int i = 0; i < 10; i++) begin
      op6(6'($urandom_range(63)), 6'($urandom_range(63)), 1'($urandom_range(1)), 1'b0, "rnd6");
    end
    op16(16'h8000, 16'h8000, 1'b1, "w16_min_sq");
    op16(16'hFFFF, 16'hFFFF, 1'b0, "w16_max_sq");
    for (int i = 0; i < 12; i++) begin
      op16(16'($urandom), 16'($urandom), 1'(i % 2), "rnd16");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 6, giving the operand width in bits; legal values are 2 to 32.

Interface
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates occur on its rising edge.
REQ-003 The port reset SHALL be an input, 1 bit wide, carrying a synchronous, active-low reset.
REQ-004 The port load SHALL be an input, 1 bit wide, carrying the start request.
REQ-005 The port signed_mode SHALL be an input, 1 bit wide: 1 means operands are two's complement, 0 means unsigned.
REQ-006 The port a SHALL be an input, WIDTH bits wide, carrying the multiplicand.
REQ-007 The port b SHALL be an input, WIDTH bits wide, carrying the multiplier.
REQ-008 The port product SHALL be an output, 2*WIDTH bits wide, carrying the registered result of the last completed operation.
REQ-009 The port busy SHALL be an output, 1 bit wide, high while an operation is in progress.
REQ-010 The port done SHALL be an output, 1 bit wide, giving a one-cycle completion pulse.

Function
REQ-011 The block SHALL implement an FSM with three states, IDLE, RUN and DONE, and SHALL have no other reachable states.
REQ-012 Accept: in IDLE or DONE, a rising edge with load=1 SHALL capture a, b and signed_mode, and SHALL move the FSM to RUN with bit counter = 0.
REQ-013 In IDLE with load=0, the FSM SHALL stay in IDLE; in DONE with load=0, the FSM SHALL move to IDLE.
REQ-014 Operand preparation at accept: if signed_mode=1, the block SHALL store the magnitudes |a| and |b| as WIDTH-bit unsigned values and SHALL record neg = a[WIDTH-1] XOR b[WIDTH-1].
REQ-015 If signed_mode=0, the block SHALL store a and b unchanged and SHALL set neg = 0.
REQ-016 RUN SHALL perform one shift-and-add step per cycle: if the current multiplier LSB is 1, add the left-shifted multiplicand into a 2*WIDTH-bit accumulator; then shift the multiplicand left 1 and the multiplier right 1.
REQ-017 RUN SHALL last exactly WIDTH cycles; on the WIDTH-th RUN edge, product SHALL be loaded with the accumulator (two's-complement negated if neg=1) and the FSM SHALL move to DONE.
REQ-018 Latency: for an accept at edge k, product becomes valid and done=1 after edge k+WIDTH.
REQ-019 busy SHALL be 1 after edges k through k+WIDTH-1 and 0 otherwise.
REQ-020 done SHALL be 1 only while in DONE, i.e. for exactly one cycle per operation.
REQ-021 Arithmetic SHALL be exact for all operands: unsigned results are in 0..(2^WIDTH-1)^2; signed results include (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) without overflow.
REQ-022 Zero operand: the result SHALL be 0 with no sign artefact, i.e. -0 = 0 when neg=1.
REQ-023 load=1 while busy=1 SHALL be ignored: operands are not recaptured and timing is unchanged.
REQ-024 Changes on a, b or signed_mode after accept SHALL NOT affect the operation in progress.
REQ-025 Back-to-back: load=1 during the DONE cycle SHALL start a new operation at that edge, giving a throughput of one result per WIDTH+1 cycles.
REQ-026 product SHALL hold its value until the next completion and SHALL NOT show partial accumulator values.

Reset
REQ-027 On a rising edge with reset=0, the FSM SHALL go to IDLE and product, busy, done, the accumulator and the bit counter SHALL clear to 0.
REQ-028 reset SHALL take priority over load.
REQ-029 Reset asserted mid-RUN SHALL abort the operation with no done pulse and product = 0.
REQ-030 Reset SHALL act only at clock edges; between edges a reset pulse SHALL have no effect.

Verification (WIDTH=6 unless stated)
REQ-031 Unsigned case: a=5, b=6, signed_mode=0, load for 1 cycle -> busy for 6 cycles, then done=1 for 1 cycle with product=12'd30.
REQ-032 Signed case: a=6'b111011 (-5), b=6, signed_mode=1 -> product=12'hFE2 (-30); also a=6'h20, b=6'h20 signed -> product=12'h400; same operands unsigned -> 12'h400; a=b=6'h3F unsigned -> 12'hF81, signed -> 12'h001.
REQ-033 Ignored load: assert load again 2 cycles after accept with a=1, b=1 -> result remains 30 and done still arrives at k+6.
REQ-034 Back-to-back: load held high continuously with a=3, b=7 -> done pulses every 7 cycles and product=12'd21 each time.
REQ-035 Reset mid-operation: reset=0 on the third RUN cycle -> busy=0, done never pulses, product=0; a later accept with 5×6 -> 30 with normal latency.
REQ-036 Width sweep: WIDTH=16 with randomised operands in both modes, checked against a reference model -> product matches and latency = 16.
